// File: rtl/video_window_3x3.sv
// rtl/video_window_3x3.sv - RGB to 8-bit luma, two line buffers and a 3x3 window with delayed syncs
// Optional BORDER_ZERO_EN macro: zero every window tap that falls outside the image.
module video_window_3x3 #(
    parameter int   MAX_WIDTH = 1920,
    parameter int   COL_W     = 11,
    parameter logic VS_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_de,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic [23:0] in_data,
    output logic        out_de,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic [71:0] out_window,
    output logic        out_border
);
    localparam int               AW      = $clog2(MAX_WIDTH);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH);
    localparam logic [COL_W-1:0] ROW_MAX = '1;

    logic [15:0]      y_sum;
    logic [COL_W-1:0] col_cnt, row_cnt;
    logic             vs_act_q;
    logic             vs_rise, de_fall;

    logic             s1_de, s1_hs, s1_vs;
    logic [7:0]       s1_y;
    logic [COL_W-1:0] s1_col, s1_row;
    logic             s1_in;
    logic [AW-1:0]    s1_idx;

    logic             s2_de, s2_hs, s2_vs;
    logic [7:0]       s2_y, rd0, rd1;
    logic [COL_W-1:0] s2_col, s2_row;
    logic             wr0, wr1;

    logic             s3_de, s3_hs, s3_vs;
    logic [COL_W-1:0] s3_col, s3_row;
    logic [71:0]      win_q;

    logic [7:0]       lb0 [MAX_WIDTH];
    logic [7:0]       lb1 [MAX_WIDTH];

    always_comb begin
        y_sum = 16'd77  * {8'd0, in_data[23:16]}
              + 16'd150 * {8'd0, in_data[15:8]}
              + 16'd29  * {8'd0, in_data[7:0]};
    end

    assign vs_rise = (in_vsync == VS_POL) && !vs_act_q;
    assign de_fall = !in_de && s1_de;
    assign s1_in   = s1_col < COL_MAX;
    assign s1_idx  = s1_col[AW-1:0];

    // S1: luma plus pixel coordinates; col_cnt is the column of the pixel currently at the input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            vs_act_q <= 1'b0;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_y     <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            vs_act_q <= (in_vsync == VS_POL);
            if (!in_de)
                col_cnt <= '0;
            else if (col_cnt != COL_MAX)
                col_cnt <= col_cnt + 1'b1;
            if (vs_rise)
                row_cnt <= '0;
            else if (de_fall && row_cnt != ROW_MAX)
                row_cnt <= row_cnt + 1'b1;
            s1_de  <= in_de;
            s1_hs  <= in_hsync;
            s1_vs  <= in_vsync;
            s1_y   <= 8'(y_sum >> 8);
            s1_col <= col_cnt;
            s1_row <= row_cnt;
        end
    end

    // Line buffers are plain RAM: no reset, read-before-write shifts LB0 into LB1
    always_ff @(posedge clk) begin
        if (s1_de && s1_in) begin
            lb0[s1_idx] <= s1_y;
            lb1[s1_idx] <= lb0[s1_idx];
        end
    end

    // S2: RAM taps, gated until each buffer has seen a full line since reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd0    <= '0;
            rd1    <= '0;
            wr0    <= 1'b0;
            wr1    <= 1'b0;
            s2_de  <= 1'b0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
            s2_y   <= '0;
            s2_col <= '0;
            s2_row <= '0;
        end else begin
            if (s1_de) begin
                rd0 <= (s1_in && wr0) ? lb0[s1_idx] : 8'h00;
                rd1 <= (s1_in && wr1) ? lb1[s1_idx] : 8'h00;
            end
            if (!s1_de && s2_de) begin
                wr0 <= 1'b1;
                wr1 <= wr0;
            end
            s2_de  <= s1_de;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_y   <= s1_y;
            s2_col <= s1_col;
            s2_row <= s1_row;
        end
    end

    // S3: window rows shift left, newest column enters at p02/p12/p22
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_de  <= 1'b0;
            s3_hs  <= 1'b0;
            s3_vs  <= 1'b0;
            s3_col <= '0;
            s3_row <= '0;
            win_q  <= '0;
        end else begin
            s3_de <= s2_de;
            s3_hs <= s2_hs;
            s3_vs <= s2_vs;
            if (s2_de) begin
                win_q  <= {win_q[63:48], rd1, win_q[39:24], rd0, win_q[15:0], s2_y};
                s3_col <= s2_col;
                s3_row <= s2_row;
            end
        end
    end

    always_comb begin
        out_window = win_q;
`ifdef BORDER_ZERO_EN
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                if ((int'(s3_row) + j < 2) || (int'(s3_col) + i < 2))
                    out_window[71-8*(3*j+i) -: 8] = 8'h00;
            end
        end
`endif
    end

    assign out_de     = s3_de;
    assign out_hsync  = s3_hs;
    assign out_vsync  = s3_vs;
    assign out_border = s3_de && ((s3_row < COL_W'(2)) || (s3_col < COL_W'(2)));
endmodule

// File: tb/tb_video_window_3x3.sv
// tb/tb_video_window_3x3.sv - randomized frames against a per-frame luma image model of video_window_3x3
module tb_video_window_3x3;
    localparam int MW = 1920;
`ifdef BORDER_ZERO_EN
    localparam bit ZMODE = 1'b1;
`else
    localparam bit ZMODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_de, in_hsync, in_vsync;
    logic [23:0] in_data;
    logic        out_de, out_hsync, out_vsync, out_border;
    logic [71:0] out_window;

    video_window_3x3 #(.MAX_WIDTH(MW), .COL_W(11), .VS_POL(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_de      (in_de),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .in_data    (in_data),
        .out_de     (out_de),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .out_window (out_window),
        .out_border (out_border)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        de, hs, vs, bd;
        logic [71:0] win;
        bit          cw, cb;
        int          sp;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  img [8][2048];
    logic [7:0]  luma_ref [4] = '{8'h4C, 8'h95, 8'hFF, 8'h00};
    logic [23:0] luma_pix [4] = '{24'hFF0000, 24'h00FF00, 24'hFFFFFF, 24'h000000};
    logic [71:0] ramp_ref = 72'h000102_101112_202122;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] luma(input logic [23:0] p);
        return 8'((77 * p[23:16] + 150 * p[15:8] + 29 * p[7:0]) >> 8);
    endfunction

    // Window centred one pixel up-left of (r,c): rows r-2..r, cols c-2..c of the current frame.
    // Line-buffer taps beyond MW were never stored and read as zero.
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        int rr, cc;
        w = '0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                rr = r - 2 + j;
                cc = c - 2 + i;
                if (rr >= 0 && cc >= 0 && !(j < 2 && cc >= MW))
                    w[71-8*(3*j+i) -: 8] = img[rr][cc];
            end
        end
        return w;
    endfunction

    task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] d,
                        input int r, input int c, input int sp, input bit chk);
        exp_t e;
        in_de    = de;
        in_hsync = hs;
        in_vsync = vs;
        in_data  = d;
        if (de) img[r][c] = luma(d);
        e.de  = de;
        e.hs  = hs;
        e.vs  = vs;
        e.bd  = de && (r < 2 || c < 2);
        e.win = exp_win(r, c);
        e.cb  = chk;
        e.cw  = chk && de && (ZMODE || !e.bd);
        e.sp  = chk ? sp : 0;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 3) begin
            e = q.pop_front();
            check("out_de", 72'(out_de), 72'(e.de));
            check("out_hsync", 72'(out_hsync), 72'(e.hs));
            check("out_vsync", 72'(out_vsync), 72'(e.vs));
            if (e.cb) check("out_border", 72'(out_border), 72'(e.bd));
            if (e.cw) check("out_window", out_window, e.win);
            if (e.sp == 1) check("ramp_window", out_window, ramp_ref);
            if (e.sp >= 2) check("luma", 72'(out_window[7:0]), 72'(luma_ref[e.sp-2]));
        end
    endtask

    // mode 0 random, 1 ramp, 2 all-white, 3 luma corner cases on row 2
    task automatic frame(input int w, input int h, input int mode, input bit vs_first, input int stop_at);
        int          n;
        int          sp;
        logic [23:0] d;
        logic [7:0]  v;
        n = 0;
        if (vs_first) begin
            step(0, 0, 1, 24'h0, 0, 0, 0, 1);
            step(0, 0, 1, 24'h0, 0, 0, 0, 1);
            step(0, 0, 0, 24'h0, 0, 0, 0, 1);
        end
        for (int r = 0; r < h; r++) begin
            step(0, 1, 0, 24'h0, r, 0, 0, 1);
            step(0, 0, 0, 24'h0, r, 0, 0, 1);
            step(0, 0, 0, 24'h0, r, 0, 0, 1);
            for (int c = 0; c < w; c++) begin
                sp = 0;
                d  = 24'($urandom);
                if (mode == 1) begin
                    v = 8'(c + 16 * r);
                    d = {v, v, v};
                    if (r == 2 && c == 2) sp = 1;
                end else if (mode == 2) begin
                    d = 24'hFFFFFF;
                end else if (mode == 3 && r == 2 && c >= 2 && c <= 5) begin
                    d  = luma_pix[c-2];
                    sp = c;
                end
                step(1, 0, 0, d, r, c, sp, 1);
                n++;
                if (n == stop_at) return;
            end
        end
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_de"}, 72'(out_de), 72'h0);
        check({tag, "_hsync"}, 72'(out_hsync), 72'h0);
        check({tag, "_vsync"}, 72'(out_vsync), 72'h0);
        check({tag, "_window"}, out_window, 72'h0);
        check({tag, "_border"}, 72'(out_border), 72'h0);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_de    = 1'b0;
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_check("rst");
        reset_n = 1'b1;

        frame(8, 4, 1, 1, -1);
        frame(6, 4, 3, 1, -1);
        for (int k = 0; k < 6; k++)
            frame(int'($urandom_range(3, 12)), int'($urandom_range(3, 5)), 0, 1, -1);

        for (int k = 0; k < 300; k++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), 7, 0, 0, 0);
        step(0, 0, 0, 24'h0, 7, 0, 0, 0);

        frame(2000, 3, 0, 1, -1);
        frame(10, 5, 2, 1, -1);

        frame(10, 4, 0, 1, 17);
        reset_n = 1'b0;
        #1;
        reset_check("rst_async");
        in_de    = 1'b0;
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        reset_check("rst_edge");
        reset_n = 1'b1;

        frame(9, 4, 0, 0, -1);
        frame(7, 3, 2, 1, -1);
        repeat (4) step(0, 0, 0, 24'h0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
